// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, state enum and result packing
// for the single-precision adder datapath.
package fp_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      DONE
   } norm_state_t;

   function automatic logic [31:0] fp_pack(
      input logic             s,
      input logic [EXP_W-1:0] e,
      input logic [MAN_W-1:0] f
   );
      return {s, e, f};
   endfunction

endpackage

// File: rtl/fp_lzc24.sv
// fp_lzc24: combinational leading-zero count of a 24-bit
// mantissa; all-zero input yields 24.
module fp_lzc24 (
   input  logic [23:0] a,
   output logic [4:0]  lz
);

   // later (higher) set bits overwrite earlier ones
   always_comb begin
      lz = 5'd24;
      for (int i = 0; i < 24; i++) begin
         if (a[i]) lz = 5'(23 - i);
      end
   end

endmodule

// File: rtl/fp_normalizer.sv
// fp_normalizer: post-add normalize and pack, valid/ready both sides.
// FP_NORM_FAST_EN selects single-cycle LZC normalization.
module fp_normalizer
   import fp_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 Sign,
   input  logic [EXP_W-1:0]     Exp,
   input  logic [MAN_W+1:0]     Mant,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          Out,
   output logic                 Ovf,
   output logic                 Unf,
   output logic                 Zero
);

   norm_state_t state;
   logic        sgn;
   logic [8:0]  exp_r;
   logic [24:0] man;
   logic [8:0]  ce;

   assign ce = exp_r + 9'd1;

`ifdef FP_NORM_FAST_EN
   logic [4:0]  lz;
   logic [8:0]  emax;
   logic [4:0]  sh;
   logic [23:0] fm;
   logic [8:0]  fe;

   fp_lzc24 u_lzc (
      .a  (man[23:0]),
      .lz (lz)
   );

   // shift limited so exp never drops below 1
   always_comb begin
      emax = exp_r - 9'd1;
      sh   = ({4'd0, lz} < emax) ? lz : emax[4:0];
      fm   = man[23:0] << sh;
      fe   = exp_r - {4'd0, sh};
   end
`endif

   // control FSM with registered result and flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         Out       <= '0;
         Ovf       <= 1'b0;
         Unf       <= 1'b0;
         Zero      <= 1'b0;
         sgn       <= 1'b0;
         exp_r     <= '0;
         man       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  sgn      <= Sign;
                  exp_r    <= (Exp == '0) ? 9'd1
                                          : {1'b0, Exp};
                  man      <= Mant;
                  in_ready <= 1'b0;
                  state    <= NORM;
               end
            end
            NORM: begin
               Ovf  <= 1'b0;
               Unf  <= 1'b0;
               Zero <= 1'b0;
               if (man[24]) begin
                  if (ce >= 9'd255) begin
                     Out <= fp_pack(sgn, EXP_MAX, '0);
                     Ovf <= 1'b1;
                  end else begin
                     Out <= fp_pack(sgn, ce[7:0],
                                    man[23:1]);
                  end
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (man == '0) begin
                  Out       <= fp_pack(sgn, '0, '0);
                  Zero      <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
`ifdef FP_NORM_FAST_EN
               end else if (fm[23]) begin
                  Out       <= fp_pack(sgn, fe[7:0],
                                       fm[22:0]);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  Out       <= fp_pack(sgn, '0, fm[22:0]);
                  Unf       <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
`else
               end else if (man[23]) begin
                  Out       <= fp_pack(sgn, exp_r[7:0],
                                       man[22:0]);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (exp_r == 9'd1) begin
                  Out       <= fp_pack(sgn, '0, man[22:0]);
                  Unf       <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  man   <= man << 1;
                  exp_r <= exp_r - 9'd1;
               end
`endif
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
